ofifo: RTL and testbench
========================

Name: ofifo

Overview:
- Opaque (non-transparent) elastic FIFO with data for the handshake dialect.
- Complement of the transparent FIFO. It has no combinational bypass, so every output is a function of registered state only.
- It cuts the forward path (valid/data) and the backward path (ready) between producer and consumer.
- Used by buffer placement wherever a channel needs both timing cut and slack, at a minimum one cycle of latency.

Parameters:
- NUM_SLOTS, 2: storage depth in tokens; must be ≥1; need not be a power of two.
- DATA_TYPE, 32: payload width in bits; must be ≥1.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- ins  input  DATA_TYPE  input payload
- ins_valid  input  1  producer offers a token
- ins_ready  output  1  FIFO accepts a token this cycle
- outs  output  DATA_TYPE  output payload (head entry)
- outs_valid  output  1  FIFO offers the head token
- outs_ready  input  1  consumer accepts the head token

Behaviour:
- State:
  - storage array mem[NUM_SLOTS], DATA_TYPE wide each.
  - head pointer (read) and tail pointer (write), each clog2(NUM_SLOTS) bits, minimum 1.
  - full flag and empty flag.
- Reset (rst=1 at a rising edge): head=0, tail=0, empty=1, full=0. The contents of mem are not reset.
- While rst=1: ins_ready=0 and outs_valid=0, regardless of state.
- Outputs outside reset:
  - outs_valid = !empty
  - ins_ready = !full
  - outs = mem[head]
  - There is no combinational path from ins, ins_valid or outs_ready to any output.
- Handshake events:
  - push = ins_valid && ins_ready
  - pop = outs_valid && outs_ready
  - On push: mem[tail] <= ins; tail advances.
  - On pop: head advances.
  - Pointer advance: p == NUM_SLOTS-1 wraps to 0, otherwise p+1.
- Flag update:
  - push only: empty<=0; full<=1 if next tail == head.
  - pop only: full<=0; empty<=1 if next head == tail.
  - push and pop together: both flags unchanged. This is only legal when the FIFO is neither empty nor full.
- Boundary conditions:
  - Empty FIFO with ins_valid=1: token is written; outs_valid rises next cycle. Minimum latency is one cycle.
  - Full FIFO: ins_ready=0 even if outs_ready=1. The slot freed by a pop accepts data from the next cycle onward.
  - Throughput is one token per cycle when NUM_SLOTS≥2.
  - With NUM_SLOTS=1, throughput is one token every two cycles.
- Protocol obligations:
  - Once outs_valid=1, outs is stable until a pop.
  - The producer must hold ins and ins_valid stable until a push occurs. The block does not check this.
- Reset mid-operation: all buffered tokens are discarded. The FIFO is empty on the first cycle after rst falls.

Optional Feature:
- Macro: OFIFO_OCCUPANCY_EN.
- Defined:
  - Adds output port count [clog2(NUM_SLOTS+1)-1:0].
  - count is a registered occupancy counter: reset to 0; +1 on push only; -1 on pop only; unchanged on both or neither.
  - Invariants: count==0 iff empty; count==NUM_SLOTS iff full.
- Not defined: neither the port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package handshake_buf_pkg:
  - clog2-based width functions for pointer and count widths.
  - Pointer-increment-with-wrap function.
- One sub-module, ofifo_storage:
  - Register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - Lets the pointer/flag control be verified independently.
- The dataless variant is a separate module that omits the data path; it is not in scope here.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then release → ins_ready=1, outs_valid=0, count=0.
- Fill and drain, NUM_SLOTS=4, DATA_TYPE=8, outs_ready=0:
  - push 0x11, 0x22, 0x33, 0x44 → ins_ready=0 after the 4th push; 5th token 0x55 held.
  - raise outs_ready → outputs 0x11..0x44 in order, then 0x55 is accepted.
- Streaming: ins_valid=1 and outs_ready=1 continuously, NUM_SLOTS=2, values 1..10:
  - first outs_valid one cycle after the first push, then one token per cycle.
  - 10 tokens out in 11 cycles.
- Wrap-around, NUM_SLOTS=3: random ins_valid/outs_ready at 50% over 200 tokens → output sequence equals input sequence; head and tail never exceed 2.
- Single slot, NUM_SLOTS=1: continuous stream → one token every 2 cycles; ins_ready and outs_valid alternate.
- Reset mid-operation with 3 tokens buffered: rst=1 for one cycle → outs_valid=0 next cycle; the next pushed value 0xAA is the first token out.

Source files
------------

// File: rtl/handshake_buf_pkg.sv
// Shared helpers for handshake buffers: pointer/count widths and
// modulo-N pointer increment for depths that need not be powers of two.
package handshake_buf_pkg;

  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/ofifo_storage.sv
// Register-array storage for ofifo: one synchronous write port and one
// asynchronous read port.
module ofifo_storage #(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_W    = 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_TYPE-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_TYPE-1:0] rdata
);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];

  // NOTE: the array has no reset; a slot is only read after a write, and the
  // empty flag masks whatever it held before.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ofifo.sv
// Opaque elastic FIFO: every output comes from registered state, cutting both
// valid/data and ready paths. Optional occupancy port: OFIFO_OCCUPANCY_EN.
module ofifo
  import handshake_buf_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
`ifdef OFIFO_OCCUPANCY_EN
  ,
  output logic [cnt_width(NUM_SLOTS)-1:0] count
`endif
);

  localparam int PTR_W = ptr_width(NUM_SLOTS);
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t head_q, head_d, tail_q, tail_d;
  logic empty_q, empty_d, full_q, full_d;
  logic push, pop;

  function automatic ptr_t advance(input ptr_t p);
    return ptr_t'(ptr_inc(32'(p), NUM_SLOTS));
  endfunction

  assign ins_ready  = !full_q && !rst;
  assign outs_valid = !empty_q && !rst;
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    empty_d = empty_q;
    full_d  = full_q;
    if (push) tail_d = advance(tail_q);
    if (pop)  head_d = advance(head_q);
    // Simultaneous push and pop leaves occupancy, hence both flags, unchanged.
    case ({push, pop})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (advance(tail_q) == head_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (advance(head_q) == tail_q);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

`ifdef OFIFO_OCCUPANCY_EN
  localparam int CNT_W = cnt_width(NUM_SLOTS);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
`endif

  ofifo_storage #(
    .NUM_SLOTS (NUM_SLOTS),
    .DATA_TYPE (DATA_TYPE),
    .ADDR_W    (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (ins),
    .raddr (head_q),
    .rdata (outs)
  );

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: four instances (depths 4, 2, 3, 1) checked
// against a queue-based reference model of the FIFO contract.
module tb_ofifo;

  localparam int NS [4] = '{4, 2, 3, 1};

  logic       clk;
  logic       rst;
  logic [7:0] ins   [4];
  logic [7:0] outs  [4];
  logic       iv    [4];
  logic       ir    [4];
  logic       ov    [4];
  logic       ordy  [4];
`ifdef OFIFO_OCCUPANCY_EN
  logic [2:0] cnt   [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : gen_dut
`ifdef OFIFO_OCCUPANCY_EN
    localparam int CW = $clog2(NS[g] + 1);
`endif
    ofifo #(.NUM_SLOTS(NS[g]), .DATA_TYPE(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins[g]),
      .ins_valid  (iv[g]),
      .ins_ready  (ir[g]),
      .outs       (outs[g]),
      .outs_valid (ov[g]),
      .outs_ready (ordy[g])
`ifdef OFIFO_OCCUPANCY_EN
      ,
      .count      (cnt[g][CW-1:0])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on instance g, compare outputs with the model, then step
  // the model across the clock edge. Called and returns at posedge+1.
  task automatic cycle(input int g, input logic v, input logic [7:0] d, input logic r,
                       output logic pushed, output logic dpop);
    int n;
    n = NS[g];
    iv[g] = v; ins[g] = d; ordy[g] = r;
    #1;
    check("ins_ready", 32'(ir[g]), 32'(mq.size() < n));
    check("outs_valid", 32'(ov[g]), 32'(mq.size() != 0));
    if (mq.size() != 0) check("outs", 32'(outs[g]), 32'(mq[0]));
`ifdef OFIFO_OCCUPANCY_EN
    check("count", 32'(cnt[g][$clog2(NS[g] + 1)-1:0]), 32'(mq.size()));
`endif
    pushed = v && (mq.size() < n);
    dpop   = ov[g] && ordy[g];
    @(posedge clk);
    if (r && mq.size() != 0) void'(mq.pop_front());
    if (pushed) mq.push_back(d);
    #1;
  endtask

  task automatic do_reset(input int g, input int cyc);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end
    repeat (cyc) begin
      #1;
      check("rst_ins_ready", 32'(ir[g]), 32'd0);
      check("rst_outs_valid", 32'(ov[g]), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    mq.delete();
  endtask

  initial begin
    logic pushed, dpop, hold, v;
    logic [7:0] data;
    int i, pops, sent, bad;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ins[k] = 8'h00;
    end
    @(posedge clk);
    #1;

    // Reset then idle
    do_reset(0, 2);
    cycle(0, 1'b0, 8'h00, 1'b0, pushed, dpop);

    // Fill and drain, depth 4
    for (int k = 1; k <= 4; k++) cycle(0, 1'b1, 8'(k * 8'h11), 1'b0, pushed, dpop);
    check("full_ready_low", 32'(ir[0]), 32'd0);
    cycle(0, 1'b1, 8'h55, 1'b0, pushed, dpop);
    check("full_held", 32'(pushed), 32'd0);
    hold = 1'b1;
    for (int c = 0; c < 20 && (hold || mq.size() != 0); c++) begin
      cycle(0, hold, 8'h55, 1'b1, pushed, dpop);
      if (pushed) hold = 1'b0;
    end
    check("fill_drain_done", 32'(hold || mq.size() != 0), 32'd0);

    // Streaming, depth 2: 10 tokens out in 11 cycles
    do_reset(1, 1);
    i = 1; pops = 0;
    for (int c = 0; c < 11; c++) begin
      cycle(1, i <= 10, 8'(i), 1'b1, pushed, dpop);
      if (pushed) i++;
      if (dpop) pops++;
      if (c == 0) check("stream_first_valid", 32'(ov[1]), 32'd1);
    end
    check("stream_pops", 32'(pops), 32'd10);

    // Wrap-around, depth 3, random handshakes
    do_reset(2, 1);
    sent = 0; bad = 0; hold = 1'b0; data = 8'($urandom);
    for (int c = 0; c < 3000 && (sent < 200 || mq.size() != 0); c++) begin
      if (!hold) hold = 1'($urandom_range(0, 1));
      v = hold && (sent < 200);
      cycle(2, v, data, 1'($urandom_range(0, 1)), pushed, dpop);
      if (pushed) begin sent++; hold = 1'b0; data = 8'($urandom); end
      if (gen_dut[2].u_dut.head_q > 2 || gen_dut[2].u_dut.tail_q > 2) bad++;
    end
    check("wrap_sent", 32'(sent), 32'd200);
    check("wrap_drained", 32'(mq.size()), 32'd0);
    check("wrap_ptr_range", 32'(bad), 32'd0);

    // Single slot: one token every two cycles
    do_reset(3, 1);
    i = 1; pops = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(3, 1'b1, 8'(i), 1'b1, pushed, dpop);
      if (pushed) i++;
      if (dpop) pops++;
      if (ir[3] === ov[3]) bad++;
    end
    check("single_pops", 32'(pops), 32'd6);
    check("single_alternate", 32'(bad), 32'd0);

    // Reset mid-operation with 3 tokens buffered
    do_reset(0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 1'b1, 8'(8'hC0 + k), 1'b0, pushed, dpop);
    iv[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_ready", 32'(ir[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    cycle(0, 1'b1, 8'hAA, 1'b0, pushed, dpop);
    #1;
    check("first_after_rst", 32'(outs[0]), 32'h0000_00AA);
    cycle(0, 1'b0, 8'h00, 1'b1, pushed, dpop);
    cycle(0, 1'b0, 8'h00, 1'b1, pushed, dpop);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
